// File: rtl/birukee_rtl_matmul_dma64.sv
// Square matrix multiply C = A*B over a 64-bit DMA: read A, read B, MAC, write C.
// Latency: 1 + 2*(1+L) + N^3 + (1+L) + 1 cycles from conf_done to acc_done, L = ceil(N*N/2).
// Backpressure: requests hold until ready; read beats wait on valid; write beats hold data until ready.
module birukee_rtl_matmul_dma64 #(
    parameter int MAX_N      = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] conf_info_matrix_size,
    input  logic [31:0] conf_info_input1,
    input  logic [31:0] conf_info_input2,
    input  logic [31:0] conf_info_output,
    input  logic        conf_done,
    output logic        dma_read_ctrl_valid,
    input  logic        dma_read_ctrl_ready,
    output logic [31:0] dma_read_ctrl_data_index,
    output logic [31:0] dma_read_ctrl_data_length,
    output logic [2:0]  dma_read_ctrl_data_size,
    input  logic        dma_read_chnl_valid,
    output logic        dma_read_chnl_ready,
    input  logic [63:0] dma_read_chnl_data,
    output logic        dma_write_ctrl_valid,
    input  logic        dma_write_ctrl_ready,
    output logic [31:0] dma_write_ctrl_data_index,
    output logic [31:0] dma_write_ctrl_data_length,
    output logic [2:0]  dma_write_ctrl_data_size,
    output logic        dma_write_chnl_valid,
    input  logic        dma_write_chnl_ready,
    output logic [63:0] dma_write_chnl_data,
    output logic        acc_done,
    output logic [31:0] debug
);
    localparam int NE = MAX_N * MAX_N;
    localparam int EW = $clog2(NE + 1);
    localparam int AW = $clog2(NE);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_RDA_REQ = 4'd1;
    localparam logic [3:0] S_RDA_DAT = 4'd2;
    localparam logic [3:0] S_RDB_REQ = 4'd3;
    localparam logic [3:0] S_RDB_DAT = 4'd4;
    localparam logic [3:0] S_COMPUTE = 4'd5;
    localparam logic [3:0] S_WR_REQ  = 4'd6;
    localparam logic [3:0] S_WR_DAT  = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    logic [3:0]            r_state;
    logic                  r_err;
    logic                  r_acc_done;
    logic [EW-1:0]         r_n;
    logic [EW-1:0]         r_nn;
    logic [EW-1:0]         r_len;
    logic [EW-1:0]         r_beat;
    logic [EW-1:0]         r_i;
    logic [EW-1:0]         r_j;
    logic [EW-1:0]         r_k;
    logic [31:0]           r_off_a;
    logic [31:0]           r_off_b;
    logic [31:0]           r_off_c;
    logic [DATA_WIDTH-1:0] r_mem_a [NE];
    logic [DATA_WIDTH-1:0] r_mem_b [NE];
    logic [DATA_WIDTH-1:0] r_mem_c [NE];

    logic                  w_n_ok;
    logic [EW-1:0]         w_conf_n;
    logic [EW-1:0]         w_conf_nn;
    logic [EW-1:0]         w_n_last;
    logic                  w_beat_last;
    logic [EW-1:0]         w_lo;
    logic [EW-1:0]         w_hi;
    logic                  w_hi_ok;
    logic [AW-1:0]         w_ia;
    logic [AW-1:0]         w_ib;
    logic [AW-1:0]         w_ic;
    logic [DATA_WIDTH-1:0] w_prod;

    // Size check is done on the full 32-bit field so huge N values cannot alias into range.
    assign w_n_ok      = (conf_info_matrix_size != 32'd0) && (conf_info_matrix_size <= 32'(MAX_N));
    assign w_conf_n    = conf_info_matrix_size[EW-1:0];
    assign w_conf_nn   = w_conf_n * w_conf_n;
    assign w_n_last    = r_n - EW'(1);
    assign w_beat_last = (r_beat == r_len - EW'(1));

    // Beat b carries elements 2b (low half) and 2b+1 (high half); the high half may be past the end.
    assign w_lo    = {r_beat[EW-2:0], 1'b0};
    assign w_hi    = w_lo | EW'(1);
    assign w_hi_ok = (w_hi < r_nn);

    // Row-major flat indices for the current multiply-accumulate step.
    assign w_ia   = AW'(r_i * r_n + r_k);
    assign w_ib   = AW'(r_k * r_n + r_j);
    assign w_ic   = AW'(r_i * r_n + r_j);
    assign w_prod = r_mem_a[w_ia] * r_mem_b[w_ib];

    // Main control FSM with configuration latch, beat and loop counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_err      <= 1'b0;
            r_acc_done <= 1'b0;
            r_n        <= '0;
            r_nn       <= '0;
            r_len      <= '0;
            r_beat     <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_off_a    <= '0;
            r_off_b    <= '0;
            r_off_c    <= '0;
        end else begin
            r_acc_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (conf_done) begin
                        r_n     <= w_conf_n;
                        r_nn    <= w_conf_nn;
                        r_len   <= (w_conf_nn + EW'(1)) >> 1;
                        r_off_a <= conf_info_input1;
                        r_off_b <= conf_info_input2;
                        r_off_c <= conf_info_output;
                        r_beat  <= '0;
                        r_err   <= !w_n_ok;
                        r_state <= w_n_ok ? S_RDA_REQ : S_DONE;
                    end
                end
                S_RDA_REQ: begin
                    if (dma_read_ctrl_ready) r_state <= S_RDA_DAT;
                end
                S_RDA_DAT: begin
                    if (dma_read_chnl_valid) begin
                        r_beat <= w_beat_last ? '0 : r_beat + EW'(1);
                        if (w_beat_last) r_state <= S_RDB_REQ;
                    end
                end
                S_RDB_REQ: begin
                    if (dma_read_ctrl_ready) r_state <= S_RDB_DAT;
                end
                S_RDB_DAT: begin
                    if (dma_read_chnl_valid) begin
                        r_beat <= w_beat_last ? '0 : r_beat + EW'(1);
                        if (w_beat_last) begin
                            r_i     <= '0;
                            r_j     <= '0;
                            r_k     <= '0;
                            r_state <= S_COMPUTE;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (r_k == w_n_last) begin
                        r_k <= '0;
                        if (r_j == w_n_last) begin
                            r_j <= '0;
                            if (r_i == w_n_last) begin
                                r_i     <= '0;
                                r_state <= S_WR_REQ;
                            end else begin
                                r_i <= r_i + EW'(1);
                            end
                        end else begin
                            r_j <= r_j + EW'(1);
                        end
                    end else begin
                        r_k <= r_k + EW'(1);
                    end
                end
                S_WR_REQ: begin
                    if (dma_write_ctrl_ready) begin
                        r_beat  <= '0;
                        r_state <= S_WR_DAT;
                    end
                end
                S_WR_DAT: begin
                    if (dma_write_chnl_ready) begin
                        r_beat <= w_beat_last ? '0 : r_beat + EW'(1);
                        if (w_beat_last) r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Unpack incoming beats into the A and B element stores.
    always_ff @(posedge clk) begin
        if (r_state == S_RDA_DAT && dma_read_chnl_valid) begin
            r_mem_a[AW'(w_lo)] <= dma_read_chnl_data[31:0];
            if (w_hi_ok) r_mem_a[AW'(w_hi)] <= dma_read_chnl_data[63:32];
        end
        if (r_state == S_RDB_DAT && dma_read_chnl_valid) begin
            r_mem_b[AW'(w_lo)] <= dma_read_chnl_data[31:0];
            if (w_hi_ok) r_mem_b[AW'(w_hi)] <= dma_read_chnl_data[63:32];
        end
    end

    // One MAC per cycle; the k==0 step overwrites so C needs no separate clear.
    always_ff @(posedge clk) begin
        if (r_state == S_COMPUTE) begin
            r_mem_c[w_ic] <= (r_k == '0) ? w_prod : r_mem_c[w_ic] + w_prod;
        end
    end

    assign dma_read_ctrl_valid        = (r_state == S_RDA_REQ) || (r_state == S_RDB_REQ);
    assign dma_read_ctrl_data_index   = (r_state == S_RDB_REQ) ? r_off_b : r_off_a;
    assign dma_read_ctrl_data_length  = {{(32-EW){1'b0}}, r_len};
    assign dma_read_ctrl_data_size    = 3'b011;
    assign dma_read_chnl_ready        = (r_state == S_RDA_DAT) || (r_state == S_RDB_DAT);

    assign dma_write_ctrl_valid       = (r_state == S_WR_REQ);
    assign dma_write_ctrl_data_index  = r_off_c;
    assign dma_write_ctrl_data_length = {{(32-EW){1'b0}}, r_len};
    assign dma_write_ctrl_data_size   = 3'b011;
    assign dma_write_chnl_valid       = (r_state == S_WR_DAT);
    assign dma_write_chnl_data        = {(w_hi_ok ? r_mem_c[AW'(w_hi)] : '0), r_mem_c[AW'(w_lo)]};

    assign acc_done = r_acc_done;
    assign debug    = {r_err, 27'd0, r_state};

endmodule

// File: tb/tb_birukee_rtl_matmul_dma64.sv
// Directed and stalled-random checks of the matmul DMA engine against hand-computed results.
// A DMA slave process serves reads from mem[] and captures writes into wmem[].
// Ready/valid on all four channels can be randomly stalled.
module tb_birukee_rtl_matmul_dma64;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] conf_info_matrix_size = '0;
    logic [31:0] conf_info_input1 = '0;
    logic [31:0] conf_info_input2 = '0;
    logic [31:0] conf_info_output = '0;
    logic        conf_done = 1'b0;
    logic        dma_read_ctrl_valid;
    logic        dma_read_ctrl_ready = 1'b0;
    logic [31:0] dma_read_ctrl_data_index;
    logic [31:0] dma_read_ctrl_data_length;
    logic [2:0]  dma_read_ctrl_data_size;
    logic        dma_read_chnl_valid = 1'b0;
    logic        dma_read_chnl_ready;
    logic [63:0] dma_read_chnl_data = '0;
    logic        dma_write_ctrl_valid;
    logic        dma_write_ctrl_ready = 1'b0;
    logic [31:0] dma_write_ctrl_data_index;
    logic [31:0] dma_write_ctrl_data_length;
    logic [2:0]  dma_write_ctrl_data_size;
    logic        dma_write_chnl_valid;
    logic        dma_write_chnl_ready = 1'b0;
    logic [63:0] dma_write_chnl_data;
    logic        acc_done;
    logic [31:0] debug;

    birukee_rtl_matmul_dma64 #(.MAX_N(8), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .conf_info_matrix_size(conf_info_matrix_size),
        .conf_info_input1(conf_info_input1), .conf_info_input2(conf_info_input2),
        .conf_info_output(conf_info_output), .conf_done(conf_done),
        .dma_read_ctrl_valid(dma_read_ctrl_valid), .dma_read_ctrl_ready(dma_read_ctrl_ready),
        .dma_read_ctrl_data_index(dma_read_ctrl_data_index),
        .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size(dma_read_ctrl_data_size),
        .dma_read_chnl_valid(dma_read_chnl_valid), .dma_read_chnl_ready(dma_read_chnl_ready),
        .dma_read_chnl_data(dma_read_chnl_data),
        .dma_write_ctrl_valid(dma_write_ctrl_valid), .dma_write_ctrl_ready(dma_write_ctrl_ready),
        .dma_write_ctrl_data_index(dma_write_ctrl_data_index),
        .dma_write_ctrl_data_length(dma_write_ctrl_data_length),
        .dma_write_ctrl_data_size(dma_write_ctrl_data_size),
        .dma_write_chnl_valid(dma_write_chnl_valid), .dma_write_chnl_ready(dma_write_chnl_ready),
        .dma_write_chnl_data(dma_write_chnl_data),
        .acc_done(acc_done), .debug(debug)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // DMA slave state
    logic [63:0] mem  [256];
    logic [63:0] wmem [256];
    logic [31:0] rd_idx_q[$], rd_len_q[$], wr_idx_q[$], wr_len_q[$];
    logic [2:0]  rd_size_q[$], wr_size_q[$];
    bit          stall = 1'b0;
    int          done_cnt = 0;
    bit          rd_active = 1'b0;
    logic [31:0] rd_base = '0, rd_len = '0, wr_base = '0;
    int          rb = 0, wb = 0;
    logic        p_rc_v, p_rc_r, p_rd_v, p_rd_r, p_wc_v, p_wc_r, p_wd_v, p_wd_r;
    logic [31:0] p_rc_idx, p_rc_len, p_wc_idx, p_wc_len;
    logic [63:0] p_wd_dat;

    function automatic logic rnd_hs();
        return stall ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_active = 1'b0; rb = 0; wb = 0;
                p_rc_v = 0; p_rc_r = 0; p_rd_v = 0; p_rd_r = 0;
                p_wc_v = 0; p_wc_r = 0; p_wd_v = 0; p_wd_r = 0;
                dma_read_ctrl_ready = 0; dma_read_chnl_valid = 0;
                dma_write_ctrl_ready = 0; dma_write_chnl_ready = 0;
            end else begin
                if (acc_done) done_cnt++;
                // stability of anything offered but not taken last cycle
                if (p_rc_v && !p_rc_r) begin
                    chk("rd_ctrl_hold_v", 64'(dma_read_ctrl_valid), 64'd1);
                    chk("rd_ctrl_hold_f", {dma_read_ctrl_data_index, dma_read_ctrl_data_length}, {p_rc_idx, p_rc_len});
                end
                if (p_wc_v && !p_wc_r) begin
                    chk("wr_ctrl_hold_v", 64'(dma_write_ctrl_valid), 64'd1);
                    chk("wr_ctrl_hold_f", {dma_write_ctrl_data_index, dma_write_ctrl_data_length}, {p_wc_idx, p_wc_len});
                end
                if (p_wd_v && !p_wd_r) chk("wr_dat_hold", dma_write_chnl_data, p_wd_dat);
                // handshakes completed on the previous rising edge
                if (p_rc_v && p_rc_r) begin
                    rd_idx_q.push_back(p_rc_idx); rd_len_q.push_back(p_rc_len);
                    rd_size_q.push_back(dma_read_ctrl_data_size);
                    rd_base = p_rc_idx; rd_len = p_rc_len; rb = 0; rd_active = (p_rc_len != 0);
                end
                if (p_rd_v && p_rd_r) begin
                    rb++;
                    if (32'(rb) >= rd_len) rd_active = 1'b0;
                end
                if (p_wc_v && p_wc_r) begin
                    wr_idx_q.push_back(p_wc_idx); wr_len_q.push_back(p_wc_len);
                    wr_size_q.push_back(dma_write_ctrl_data_size);
                    wr_base = p_wc_idx; wb = 0;
                end
                if (p_wd_v && p_wd_r) begin
                    wmem[8'(wr_base + 32'(wb))] = p_wd_dat;
                    wb++;
                end
                // drive next cycle
                dma_read_ctrl_ready  = rnd_hs();
                dma_read_chnl_valid  = rd_active && rnd_hs();
                dma_read_chnl_data   = rd_active ? mem[8'(rd_base + 32'(rb))] : 64'd0;
                dma_write_ctrl_ready = rnd_hs();
                dma_write_chnl_ready = rnd_hs();
                p_rc_v = dma_read_ctrl_valid;  p_rc_r = dma_read_ctrl_ready;
                p_rc_idx = dma_read_ctrl_data_index; p_rc_len = dma_read_ctrl_data_length;
                p_rd_v = dma_read_chnl_valid;  p_rd_r = dma_read_chnl_ready;
                p_wc_v = dma_write_ctrl_valid; p_wc_r = dma_write_ctrl_ready;
                p_wc_idx = dma_write_ctrl_data_index; p_wc_len = dma_write_ctrl_data_length;
                p_wd_v = dma_write_chnl_valid; p_wd_r = dma_write_chnl_ready;
                p_wd_dat = dma_write_chnl_data;
            end
        end
    end

    task automatic put_elem(input logic [31:0] base, input int k, input logic [31:0] v);
        logic [7:0] a;
        a = 8'(base + 32'(k / 2));
        if (k % 2 != 0) mem[a][63:32] = v;
        else            mem[a][31:0]  = v;
    endtask

    function automatic logic [31:0] get_c(input logic [31:0] base, input int k);
        logic [7:0] a;
        a = 8'(base + 32'(k / 2));
        return (k % 2 != 0) ? wmem[a][63:32] : wmem[a][31:0];
    endfunction

    task automatic clear_logs();
        rd_idx_q.delete(); rd_len_q.delete(); rd_size_q.delete();
        wr_idx_q.delete(); wr_len_q.delete(); wr_size_q.delete();
        for (int i = 0; i < 256; i++) wmem[i] = 64'hA5A5A5A5_A5A5A5A5;
    endtask

    task automatic start_op(input int n, input logic [31:0] i1, input logic [31:0] i2, input logic [31:0] o);
        @(negedge clk);
        conf_info_matrix_size = 32'(n);
        conf_info_input1 = i1; conf_info_input2 = i2; conf_info_output = o;
        conf_done = 1'b1;
        @(negedge clk);
        conf_done = 1'b0;
    endtask

    // Returns the cycle offset of acc_done relative to the conf_done cycle.
    task automatic wait_done(input string name, input bit extra, output int lat);
        int t;
        t = 1;
        while (acc_done !== 1'b1 && t < 5000) begin
            if (extra && t == 20) begin
                conf_info_matrix_size = 32'd0;
                conf_done = 1'b1;
            end else begin
                conf_done = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        conf_done = 1'b0;
        chk({name, "_done_seen"}, 64'(acc_done), 64'd1);
        lat = t;
        @(negedge clk);
        chk({name, "_done_pulse"}, 64'(acc_done), 64'd0);
    endtask

    task automatic run_op(input string name, input int n, input logic [31:0] i1, input logic [31:0] i2,
                          input logic [31:0] o, input bit extra, input logic [31:0] exp_dbg, output int lat);
        start_op(n, i1, i2, o);
        chk({name, "_dbg_first"}, 64'(debug), 64'(exp_dbg));
        wait_done(name, extra, lat);
    endtask

    logic [63:0] exp_n3 [5];
    logic [31:0] ma [64];
    logic [31:0] mb [64];
    logic [31:0] acc;
    int          lat;
    int          d0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 64'hDEADBEEF_DEADBEEF;
        clear_logs();
        rst = 1'b0;
        #1 rst = 1'b1;
        #11;
        chk("rst_acc_done", 64'(acc_done), 64'd0);
        chk("rst_rd_ctrl_v", 64'(dma_read_ctrl_valid), 64'd0);
        chk("rst_rd_chnl_r", 64'(dma_read_chnl_ready), 64'd0);
        chk("rst_wr_ctrl_v", 64'(dma_write_ctrl_valid), 64'd0);
        chk("rst_wr_chnl_v", 64'(dma_write_chnl_valid), 64'd0);
        chk("rst_debug", 64'(debug), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // N=2 basic product
        for (int k = 0; k < 4; k++) begin
            put_elem(32'd0, k, 32'(k + 1));
            put_elem(32'd2, k, 32'(k + 5));
        end
        clear_logs();
        run_op("n2", 2, 32'd0, 32'd2, 32'd4, 1'b0, 32'h1, lat);
        chk("n2_latency", 64'(lat), 64'd19);
        chk("n2_rd_count", 64'(rd_idx_q.size()), 64'd2);
        if (rd_idx_q.size() >= 2) begin
            chk("n2_rd0", {rd_idx_q[0], rd_len_q[0]}, {32'd0, 32'd2});
            chk("n2_rd1", {rd_idx_q[1], rd_len_q[1]}, {32'd2, 32'd2});
            chk("n2_rd_size", 64'(rd_size_q[0]), 64'd3);
        end
        chk("n2_wr_count", 64'(wr_idx_q.size()), 64'd1);
        if (wr_idx_q.size() >= 1) begin
            chk("n2_wr", {wr_idx_q[0], wr_len_q[0]}, {32'd4, 32'd2});
            chk("n2_wr_size", 64'(wr_size_q[0]), 64'd3);
        end
        chk("n2_beat0", wmem[4], {32'd22, 32'd19});
        chk("n2_beat1", wmem[5], {32'd50, 32'd43});

        // Out-of-range sizes go straight to DONE with the error flag
        clear_logs();
        run_op("n0", 0, 32'd0, 32'd2, 32'd4, 1'b0, 32'h80000008, lat);
        chk("n0_latency", 64'(lat), 64'd2);
        chk("n0_no_dma", 64'(rd_idx_q.size() + wr_idx_q.size()), 64'd0);
        chk("n0_err_idle", 64'(debug), 64'h80000000);
        clear_logs();
        run_op("n9", 9, 32'd0, 32'd2, 32'd4, 1'b0, 32'h80000008, lat);
        chk("n9_latency", 64'(lat), 64'd2);
        chk("n9_no_dma", 64'(rd_idx_q.size() + wr_idx_q.size()), 64'd0);

        // N=3 identity times 1..9, odd final beat; stray conf_done mid-compute is ignored
        for (int k = 0; k < 9; k++) begin
            put_elem(32'd10, k, (k / 3 == k % 3) ? 32'd1 : 32'd0);
            put_elem(32'd20, k, 32'(k + 1));
        end
        exp_n3[0] = {32'd2, 32'd1}; exp_n3[1] = {32'd4, 32'd3}; exp_n3[2] = {32'd6, 32'd5};
        exp_n3[3] = {32'd8, 32'd7}; exp_n3[4] = {32'd0, 32'd9};
        clear_logs();
        run_op("n3", 3, 32'd10, 32'd20, 32'd30, 1'b1, 32'h1, lat);
        chk("n3_latency", 64'(lat), 64'd47);
        if (rd_len_q.size() >= 1) chk("n3_rd_len", 64'(rd_len_q[0]), 64'd5);
        if (wr_len_q.size() >= 1) chk("n3_wr_len", 64'(wr_len_q[0]), 64'd5);
        for (int b = 0; b < 5; b++) chk($sformatf("n3_beat%0d", b), wmem[30 + b], exp_n3[b]);

        // Modulo wrap: (2^32-1)^2 = 1 mod 2^32, summed twice
        for (int k = 0; k < 4; k++) begin
            put_elem(32'd40, k, 32'hFFFFFFFF);
            put_elem(32'd50, k, 32'hFFFFFFFF);
        end
        clear_logs();
        run_op("wrap", 2, 32'd40, 32'd50, 32'd60, 1'b0, 32'h1, lat);
        chk("wrap_latency", 64'(lat), 64'd19);
        chk("wrap_beat0", wmem[60], 64'h00000002_00000002);
        chk("wrap_beat1", wmem[61], 64'h00000002_00000002);

        // N=MAX_N random data with ~50% stalls on every channel
        for (int k = 0; k < 64; k++) begin
            ma[k] = $urandom; mb[k] = $urandom;
            put_elem(32'd100, k, ma[k]);
            put_elem(32'd140, k, mb[k]);
        end
        clear_logs();
        stall = 1'b1;
        run_op("rand", 8, 32'd100, 32'd140, 32'd200, 1'b0, 32'h1, lat);
        stall = 1'b0;
        if (rd_len_q.size() >= 2) chk("rand_rd_len", {rd_len_q[0], rd_len_q[1]}, {32'd32, 32'd32});
        if (wr_len_q.size() >= 1) chk("rand_wr_len", 64'(wr_len_q[0]), 64'd32);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                acc = '0;
                for (int k = 0; k < 8; k++) acc = acc + ma[i * 8 + k] * mb[k * 8 + j];
                chk($sformatf("rand_c%0d_%0d", i, j), 64'(get_c(32'd200, i * 8 + j)), 64'(acc));
            end
        end

        // Reset during COMPUTE abandons the run
        clear_logs();
        start_op(2, 32'd0, 32'd2, 32'd70);
        for (int t = 0; t < 40; t++) begin
            if (debug[3:0] == 4'd5) break;
            @(negedge clk);
        end
        chk("rst_reach_compute", 64'(debug[3:0]), 64'd5);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        chk("arst_debug", 64'(debug), 64'd0);
        chk("arst_valids", 64'({dma_read_ctrl_valid, dma_read_chnl_ready, dma_write_ctrl_valid, dma_write_chnl_valid}), 64'd0);
        chk("arst_acc_done", 64'(acc_done), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("arst_no_done", 64'(done_cnt), 64'(d0));
        chk("arst_no_write", 64'(wr_idx_q.size()), 64'd0);
        clear_logs();
        run_op("post_rst", 2, 32'd0, 32'd2, 32'd70, 1'b0, 32'h1, lat);
        chk("post_rst_latency", 64'(lat), 64'd19);
        chk("post_rst_beat0", wmem[70], {32'd22, 32'd19});
        chk("post_rst_beat1", wmem[71], {32'd50, 32'd43});
        chk("total_done_pulses", 64'(done_cnt), 64'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/birukee_rtl_matmul_dma64.md
BIRUKEE_RTL_MATMUL_DMA64 -- requirements
Module: birukee_rtl_matmul_dma64

Interface
REQ-001 Parameter MAX_N, default 8: largest supported square matrix dimension.
REQ-002 Parameter DATA_WIDTH, default 32: element width; SHALL be 32, so two elements are packed per 64-bit beat.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 conf_info_matrix_size  in  32  N, the matrix dimension.
REQ-006 conf_info_input1, conf_info_input2, conf_info_output  in  32 each  beat offsets of matrix A, matrix B and result C.
REQ-007 conf_done  in  1  one-cycle start pulse; conf_info_* is valid on that cycle.
REQ-008 dma_read_ctrl_{valid out 1, ready in 1, data_index out 32, data_length out 32, data_size out 3}  read request.
REQ-009 dma_read_chnl_{valid in 1, ready out 1, data in 64}  read data.
REQ-010 dma_write_ctrl_{valid, ready, data_index, data_length, data_size}  write request, same widths as read.
REQ-011 dma_write_chnl_{valid out 1, ready in 1, data out 64}  write data.
REQ-012 acc_done  out  1  one-cycle completion pulse; debug  out  32  status.

Function
REQ-013 The FSM SHALL have the states IDLE, RDA_REQ, RDA_DAT, RDB_REQ, RDB_DAT, COMPUTE, WR_REQ, WR_DAT and DONE, encoded 0-8 in that order.
REQ-014 IDLE + conf_done: latch N and the three offsets. If 1<=N<=MAX_N, go to RDA_REQ; otherwise go to DONE and set debug[31].
REQ-015 Beat count L = ceil(N*N/2).
REQ-016 Element k is in beat k/2: bits [31:0] when k is even, [63:32] when k is odd. Layout is row-major.
REQ-017 Every request SHALL drive data_length = L and data_size = 3'b011.
REQ-018 A request SHALL hold valid high with stable fields until the cycle in which valid and ready are both high; the FSM then advances.
REQ-019 RDA_REQ/RDB_REQ SHALL use index = input1/input2 respectively.
REQ-020 In RDx_DAT, read_chnl_ready SHALL be 1. Each valid beat stores two elements (the unused high half of an odd final beat is dropped). After beat L the FSM advances.
REQ-021 read_chnl_ready SHALL be 0 in all other states.
REQ-022 COMPUTE SHALL perform one multiply-accumulate per cycle: C[i][j] += A[i][k]*B[k][j], with k innermost, then j, then i.
REQ-023 Products and sums SHALL be truncated modulo 2^32.
REQ-024 COMPUTE SHALL last exactly N^3 cycles, after which the FSM goes to WR_REQ.
REQ-025 WR_REQ SHALL use index = conf_info_output as latched.
REQ-026 In WR_DAT, write_chnl_valid SHALL be 1 with beat b = {C[2b+1], C[2b]}; the high half of an odd final beat SHALL be 0.
REQ-027 write_chnl_data SHALL be held stable while ready is low. After beat L is accepted, the FSM goes to DONE.
REQ-028 DONE SHALL assert acc_done for exactly one cycle, then return to IDLE.
REQ-029 conf_done outside IDLE SHALL be ignored.
REQ-030 debug[3:0] = current state, debug[31] = error flag, and all other debug bits = 0.
REQ-031 The error flag SHALL clear on the next accepted conf_done.
REQ-032 Latency from conf_done to acc_done with ready/valid always high: 1 + 2*(1+L) + N^3 + (1+L) + 1 cycles.

Reset
REQ-033 rst high SHALL, immediately and asynchronously, set the state to IDLE and drive all valid outputs, read_chnl_ready, acc_done and debug to 0.
REQ-034 rst SHALL clear all counters and the error flag.
REQ-035 Matrix storage need not be cleared by reset.
REQ-036 Reset mid-transfer SHALL abandon the operation with no acc_done. The next conf_done SHALL start a fresh operation.

Verification
REQ-037 N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], offsets 0/2/4, ready always high -> one read at index 0 of length 2, one at index 2 of length 2, a write at index 4 of length 2 with beats {22,19},{50,43}, and acc_done at the cycle given by REQ-032.
REQ-038 N=3, A=identity, B=1..9 -> L=5; write beats {2,1},{4,3},{6,5},{8,7},{0,9}.
REQ-039 N=0 and N=MAX_N+1 -> no DMA activity; acc_done 2 cycles after conf_done; debug=0x80000008 during DONE.
REQ-040 Random ready/valid stalls (about 50%) on all four channels with N=MAX_N random data -> result matches the modulo-2^32 reference model; request fields and write data stay stable while stalled.
REQ-041 Elements 0xFFFFFFFF, N=2 -> every C element = 0x00000002, showing modulo wrap.
REQ-042 rst asserted in COMPUTE, then a new conf_done with N=2 -> all outputs are 0 immediately, no acc_done for the aborted run, and the second run is correct.
